// File: rtl/marble_launcher.sv
// Upstream marble source: releases one blue or red marble at a time as a pulse
// into the top of the cell network, paced by the bottom levers, until a
// reservoir runs dry, an interceptor captures, or a marble is lost in flight.
module marble_launcher #(
  parameter int BLUE_INIT = 8,
  parameter int RED_INIT  = 8,
  parameter int CNT_W     = 4,
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_trig_left,
  input  logic             i_trig_right,
  input  logic             i_halt,
  input  logic             i_reload,
  output logic             o_left,
  output logic             o_right,
  output logic [CNT_W-1:0] o_blue_cnt,
  output logic [CNT_W-1:0] o_red_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_empty,
  output logic             o_timeout
);

  localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(PULSE_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLUE_LOAD  = CNT_W'(BLUE_INIT);
  localparam logic [CNT_W-1:0] RED_LOAD   = CNT_W'(RED_INIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_FLIGHT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] blue_cnt_q, blue_cnt_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
  logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             halt_seen_q, halt_seen_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             empty_q, empty_d;
  logic             timeout_q, timeout_d;

  // Levers are sampled once, then compared with the previous sample; the edge
  // is therefore visible for exactly one cycle, one cycle after the input rises.
  logic start_smp_q, start_smp_d, start_prv_q, start_prv_d;
  logic left_smp_q, left_smp_d, left_prv_q, left_prv_d;
  logic right_smp_q, right_smp_d, right_prv_q, right_prv_d;
  logic start_edge, left_edge, right_edge;

  logic launch_req;
  logic launch_blue;

  always_comb begin
    start_smp_d = i_start;
    start_prv_d = start_smp_q;
    left_smp_d  = i_trig_left;
    left_prv_d  = left_smp_q;
    right_smp_d = i_trig_right;
    right_prv_d = right_smp_q;
    start_edge  = start_smp_q & ~start_prv_q;
    left_edge   = left_smp_q  & ~left_prv_q;
    right_edge  = right_smp_q & ~right_prv_q;
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    blue_cnt_d  = blue_cnt_q;
    red_cnt_d   = red_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    timer_d     = timer_q;
    halt_seen_d = halt_seen_q;
    left_d      = left_q;
    right_d     = right_q;
    empty_d     = empty_q;
    timeout_d   = timeout_q;
    launch_req  = 1'b0;
    launch_blue = 1'b1;

    if (i_reload) begin
      state_d     = ST_IDLE;
      blue_cnt_d  = BLUE_LOAD;
      red_cnt_d   = RED_LOAD;
      pulse_cnt_d = '0;
      timer_d     = '0;
      halt_seen_d = 1'b0;
      left_d      = 1'b0;
      right_d     = 1'b0;
      empty_d     = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: launch_req = start_edge;

        ST_PULSE: begin
          // A halt during the pulse must not truncate it; remember it instead.
          halt_seen_d = halt_seen_q | i_halt;
          if (pulse_cnt_q == PULSE_LAST) begin
            left_d      = 1'b0;
            right_d     = 1'b0;
            pulse_cnt_d = '0;
            timer_d     = '0;
            state_d     = (halt_seen_q | i_halt) ? ST_DONE : ST_FLIGHT;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end

        ST_FLIGHT: begin
          if (i_halt) begin
            state_d = ST_DONE;
          end else if (left_edge) begin
            launch_req = 1'b1;
          end else if (right_edge) begin
            launch_req  = 1'b1;
            launch_blue = 1'b0;
          end else if (timer_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        default: ;
      endcase

      if (launch_req) begin
        if (launch_blue ? (blue_cnt_q == '0) : (red_cnt_q == '0)) begin
          empty_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d     = ST_PULSE;
          pulse_cnt_d = '0;
          halt_seen_d = 1'b0;
          left_d      = launch_blue;
          right_d     = ~launch_blue;
          if (launch_blue) blue_cnt_d = blue_cnt_q - 1'b1;
          else             red_cnt_d  = red_cnt_q - 1'b1;
        end
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      blue_cnt_q  <= BLUE_LOAD;
      red_cnt_q   <= RED_LOAD;
      pulse_cnt_q <= '0;
      timer_q     <= '0;
      halt_seen_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      empty_q     <= 1'b0;
      timeout_q   <= 1'b0;
      start_smp_q <= 1'b0;
      start_prv_q <= 1'b0;
      left_smp_q  <= 1'b0;
      left_prv_q  <= 1'b0;
      right_smp_q <= 1'b0;
      right_prv_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blue_cnt_q  <= blue_cnt_d;
      red_cnt_q   <= red_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      timer_q     <= timer_d;
      halt_seen_q <= halt_seen_d;
      left_q      <= left_d;
      right_q     <= right_d;
      empty_q     <= empty_d;
      timeout_q   <= timeout_d;
      start_smp_q <= start_smp_d;
      start_prv_q <= start_prv_d;
      left_smp_q  <= left_smp_d;
      left_prv_q  <= left_prv_d;
      right_smp_q <= right_smp_d;
      right_prv_q <= right_prv_d;
    end
  end

  assign o_left     = left_q;
  assign o_right    = right_q;
  assign o_blue_cnt = blue_cnt_q;
  assign o_red_cnt  = red_cnt_q;
  assign o_busy     = (state_q == ST_PULSE) || (state_q == ST_FLIGHT);
  assign o_done     = (state_q == ST_DONE);
  assign o_empty    = empty_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_marble_launcher.sv
// Self-checking bench for marble_launcher: directed scenarios against fixed
// expectations plus randomized levers against a cycle-level behavioural model.
module tb_marble_launcher;

  localparam int BLUE_INIT = 8;
  localparam int RED_INIT  = 8;
  localparam int CNT_W     = 4;
  localparam int PULSE_LEN = 2;
  localparam int TIMEOUT   = 255;
  localparam int TO_W      = 8;
  localparam int VW        = 2 * CNT_W + 6;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start, i_trig_left, i_trig_right, i_halt, i_reload;
  logic             o_left, o_right, o_busy, o_done, o_empty, o_timeout;
  logic [CNT_W-1:0] o_blue_cnt, o_red_cnt;

  marble_launcher #(
    .BLUE_INIT(BLUE_INIT), .RED_INIT(RED_INIT), .CNT_W(CNT_W),
    .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_trig_left(i_trig_left), .i_trig_right(i_trig_right),
    .i_halt(i_halt), .i_reload(i_reload),
    .o_left(o_left), .o_right(o_right),
    .o_blue_cnt(o_blue_cnt), .o_red_cnt(o_red_cnt),
    .o_busy(o_busy), .o_done(o_done), .o_empty(o_empty), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: reservoirs, a pulse countdown, a flight age and a run flag.
  int m_blue, m_red, pulse_rem, flight_age;
  bit m_empty, m_timeout, m_done, m_started, pulse_blue, halt_flag;
  bit smp_s, prv_s, smp_l, prv_l, smp_r, prv_r;

  function automatic logic [VW-1:0] pk(bit l, bit r, int b, int rd,
                                       bit bz, bit dn, bit em, bit to);
    return {l, r, CNT_W'(b), CNT_W'(rd), bz, dn, em, to};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {o_left, o_right, o_blue_cnt, o_red_cnt, o_busy, o_done, o_empty, o_timeout};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return pk(pulse_rem > 0 && pulse_blue, pulse_rem > 0 && !pulse_blue, m_blue, m_red,
              m_started && !m_done, m_done, m_empty, m_timeout);
  endfunction

  task automatic model_load();
    m_blue = BLUE_INIT; m_red = RED_INIT;
    m_empty = 0; m_timeout = 0; m_done = 0; m_started = 0;
    pulse_rem = 0; flight_age = 0; halt_flag = 0; pulse_blue = 0;
  endtask

  task automatic model_reset();
    model_load();
    smp_s = 0; prv_s = 0; smp_l = 0; prv_l = 0; smp_r = 0; prv_r = 0;
  endtask

  task automatic model_launch(bit blue);
    if (blue ? m_blue == 0 : m_red == 0) begin
      m_empty = 1; m_done = 1;
    end else begin
      if (blue) m_blue--; else m_red--;
      pulse_rem = PULSE_LEN; pulse_blue = blue; halt_flag = 0; m_started = 1;
    end
  endtask

  task automatic model_step();
    bit ev_s, ev_l, ev_r;
    ev_s = smp_s & ~prv_s; ev_l = smp_l & ~prv_l; ev_r = smp_r & ~prv_r;
    prv_s = smp_s; smp_s = i_start;
    prv_l = smp_l; smp_l = i_trig_left;
    prv_r = smp_r; smp_r = i_trig_right;
    if (i_reload) begin
      model_load();
    end else if (m_done) begin
      // finished run: wait for reload
    end else if (pulse_rem > 0) begin
      if (i_halt) halt_flag = 1;
      pulse_rem--;
      if (pulse_rem == 0) begin
        if (halt_flag) m_done = 1;
        else flight_age = 0;
      end
    end else if (m_started) begin
      if (i_halt) m_done = 1;
      else if (ev_l) model_launch(1);
      else if (ev_r) model_launch(0);
      else begin
        flight_age++;
        if (flight_age == TIMEOUT) begin m_timeout = 1; m_done = 1; end
      end
    end else if (ev_s) begin
      model_launch(1);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (!i_rst_n) model_reset(); else model_step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_start = 0; i_trig_left = 0; i_trig_right = 0; i_halt = 0; i_reload = 0;
  endtask

  task automatic do_reload();
    idle_inputs(); i_reload = 1; tick(); i_reload = 0; tick();
  endtask

  task automatic test_reset();
    idle_inputs(); i_rst_n = 0; model_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_state: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
    i_rst_n = 1; tick(); tick();
    checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_idle: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
  endtask

  task automatic test_launch();
    logic [VW-1:0] exp_seq [4];
    exp_seq = '{pk(0, 0, 8, 8, 0, 0, 0, 0), pk(1, 0, 7, 8, 1, 0, 0, 0),
                pk(1, 0, 7, 8, 1, 0, 0, 0), pk(0, 0, 7, 8, 1, 0, 0, 0)};
    i_start = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); checks++;
      if (dut_vec() !== exp_seq[i]) begin
        errors++; $display("FAIL launch_cycle%0d: got %h want %h", i, dut_vec(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_right_then_both();
    logic [VW-1:0] exp_r [4];
    logic [VW-1:0] exp_b [6];
    exp_r = '{pk(0, 0, 7, 8, 1, 0, 0, 0), pk(0, 1, 7, 7, 1, 0, 0, 0),
              pk(0, 1, 7, 7, 1, 0, 0, 0), pk(0, 0, 7, 7, 1, 0, 0, 0)};
    exp_b = '{pk(0, 0, 7, 7, 1, 0, 0, 0), pk(1, 0, 6, 7, 1, 0, 0, 0),
              pk(1, 0, 6, 7, 1, 0, 0, 0), pk(0, 0, 6, 7, 1, 0, 0, 0),
              pk(0, 0, 6, 7, 1, 0, 0, 0), pk(0, 0, 6, 7, 1, 0, 0, 0)};
    i_trig_right = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); checks++;
      if (dut_vec() !== exp_r[i]) begin
        errors++; $display("FAIL right_cycle%0d: got %h want %h", i, dut_vec(), exp_r[i]);
      end
    end
    i_trig_right = 0; tick(); tick();
    i_trig_left = 1; i_trig_right = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); checks++;
      if (dut_vec() !== exp_b[i]) begin
        errors++; $display("FAIL both_cycle%0d: got %h want %h", i, dut_vec(), exp_b[i]);
      end
    end
    i_trig_left = 0; i_trig_right = 0;
  endtask

  task automatic test_halt_in_pulse();
    do_reload();
    i_start = 1; tick(); tick();
    i_halt = 1; tick(); checks++;
    if (dut_vec() !== pk(1, 0, 7, 8, 1, 0, 0, 0)) begin
      errors++; $display("FAIL halt_pulse_kept: got %h want %h", dut_vec(), pk(1, 0, 7, 8, 1, 0, 0, 0));
    end
    tick(); checks++;
    if (dut_vec() !== pk(0, 0, 7, 8, 0, 1, 0, 0)) begin
      errors++; $display("FAIL halt_done: got %h want %h", dut_vec(), pk(0, 0, 7, 8, 0, 1, 0, 0));
    end
    i_halt = 0;
  endtask

  task automatic test_reload();
    i_trig_left = 1; tick(); tick(); tick(); checks++;
    if (dut_vec() !== pk(0, 0, 7, 8, 0, 1, 0, 0)) begin
      errors++; $display("FAIL done_ignores_lever: got %h want %h", dut_vec(), pk(0, 0, 7, 8, 0, 1, 0, 0));
    end
    idle_inputs(); i_reload = 1; tick(); checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reload_idle: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
    i_reload = 0; tick();
  endtask

  task automatic test_timeout();
    i_start = 1;
    repeat (258) tick();
    checks++;
    if (dut_vec() !== pk(0, 0, 7, 8, 1, 0, 0, 0)) begin
      errors++; $display("FAIL timeout_early: got %h want %h", dut_vec(), pk(0, 0, 7, 8, 1, 0, 0, 0));
    end
    tick(); checks++;
    if (dut_vec() !== pk(0, 0, 7, 8, 0, 1, 0, 1)) begin
      errors++; $display("FAIL timeout_hit: got %h want %h", dut_vec(), pk(0, 0, 7, 8, 0, 1, 0, 1));
    end
    i_trig_left = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); checks++;
      if (dut_vec() !== pk(0, 0, 7, 8, 0, 1, 0, 1)) begin
        errors++; $display("FAIL timeout_lever%0d: got %h want %h", i, dut_vec(), pk(0, 0, 7, 8, 0, 1, 0, 1));
      end
    end
    do_reload(); checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL timeout_cleared: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
  endtask

  task automatic test_empty();
    i_start = 1; repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      i_trig_left = 1; tick(); i_trig_left = 0; repeat (3) tick();
    end
    checks++;
    if (dut_vec() !== pk(0, 0, 0, 8, 1, 0, 0, 0)) begin
      errors++; $display("FAIL empty_drained: got %h want %h", dut_vec(), pk(0, 0, 0, 8, 1, 0, 0, 0));
    end
    i_trig_left = 1; tick(); tick(); checks++;
    if (dut_vec() !== pk(0, 0, 0, 8, 0, 1, 1, 0)) begin
      errors++; $display("FAIL empty_flag: got %h want %h", dut_vec(), pk(0, 0, 0, 8, 0, 1, 1, 0));
    end
    do_reload(); checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL empty_cleared: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_pulse();
    i_start = 1; tick(); tick();
    #2 i_rst_n = 0;
    #1 checks++;
    if (dut_vec() !== pk(0, 0, 8, 8, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset_pulse: got %h want %h", dut_vec(), pk(0, 0, 8, 8, 0, 0, 0, 0));
    end
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    tick(); tick(); checks++;
    if (dut_vec() !== pk(1, 0, 7, 8, 1, 0, 0, 0)) begin
      errors++; $display("FAIL start_high_at_reset: got %h want %h", dut_vec(), pk(1, 0, 7, 8, 1, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    bit quiet;
    idle_inputs(); i_rst_n = 0; model_reset();
    @(negedge i_clk); i_rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      quiet = (c % 1000) >= 600;
      if (!quiet) begin
        if ($urandom_range(0, 5) == 0) i_start = ~i_start;
        if ($urandom_range(0, 3) == 0) i_trig_left = ~i_trig_left;
        if ($urandom_range(0, 3) == 0) i_trig_right = ~i_trig_right;
        i_halt = ($urandom_range(0, 29) == 0);
      end else begin
        i_halt = 0;
      end
      i_reload = ($urandom_range(0, 149) == 0);
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_launch();
    test_right_then_both();
    test_halt_in_pulse();
    test_reload();
    test_timeout();
    test_empty();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
